memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Two-requester memory bus arbiter: instruction fetch vs. load/store.
// Data wins by default; fetch is forced through once its starve count reaches STARVE_LIMIT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; arbitrate and latch winner on exit
// ACCESS  | single-cycle read or write enable on the memory bus
// WAIT    | read in flight, MEM_LATENCY-1 cycles (skipped when latency=1)
// CAPTURE | memory data valid; register into winner's data output
// RESPOND | one-cycle ready pulse to the winner

module memory_bus_arbiter #(
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_address,
   output logic        fetch_ready,
   output logic [31:0] fetch_data,
   input  logic        data_req,
   input  logic        data_write,
   input  logic [31:0] data_address,
   input  logic [31:0] data_write_data,
   input  logic [2:0]  data_format,
   output logic        data_ready,
   output logic [31:0] data_fetched,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [2:0]  mem_format,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   input  logic [31:0] mem_data_fetched
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS  = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      RESPOND = 3'd4
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [2:0] WAIT_LOAD  = (MEM_LATENCY > 1) ? 3'(MEM_LATENCY - 2) : 3'd0;
   localparam logic [2:0] FMT_WORD   = 3'b010;

   state_t      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [2:0]  wait_cnt_q, wait_cnt_d;
   logic        gnt_fetch_q, gnt_fetch_d;
   logic        is_write_q, is_write_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;
   logic [2:0]  mem_format_q, mem_format_d;
   logic        mem_read_enable_q, mem_read_enable_d;
   logic        mem_write_enable_q, mem_write_enable_d;
   logic        fetch_ready_q, fetch_ready_d;
   logic        data_ready_q, data_ready_d;
   logic [31:0] fetch_data_q, fetch_data_d;
   logic [31:0] data_fetched_q, data_fetched_d;
   logic        fetch_wins;

   always_comb begin
      state_d            = state_q;
      starve_d           = starve_q;
      wait_cnt_d         = wait_cnt_q;
      gnt_fetch_d        = gnt_fetch_q;
      is_write_d         = is_write_q;
      mem_address_d      = mem_address_q;
      mem_write_data_d   = mem_write_data_q;
      mem_format_d       = mem_format_q;
      mem_read_enable_d  = 1'b0;
      mem_write_enable_d = 1'b0;
      fetch_ready_d      = 1'b0;
      data_ready_d       = 1'b0;
      fetch_data_d       = fetch_data_q;
      data_fetched_d     = data_fetched_q;
      fetch_wins         = fetch_req && (!data_req || (starve_q >= STARVE_MAX));

      unique case (state_q)
         IDLE: begin
            if (fetch_req || data_req) begin
               state_d     = ACCESS;
               gnt_fetch_d = fetch_wins;
               if (fetch_wins) begin
                  mem_address_d     = fetch_address;
                  mem_write_data_d  = '0;
                  mem_format_d      = FMT_WORD;
                  is_write_d        = 1'b0;
                  mem_read_enable_d = 1'b1;
                  starve_d          = '0;
               end else begin
                  mem_address_d      = data_address;
                  mem_write_data_d   = data_write_data;
                  mem_format_d       = data_format;
                  is_write_d         = data_write;
                  mem_read_enable_d  = !data_write;
                  mem_write_enable_d = data_write;
                  // Count only data grants that made a waiting fetch lose.
                  if (!fetch_req) begin
                     starve_d = '0;
                  end else if (starve_q < STARVE_MAX) begin
                     starve_d = starve_q + 4'd1;
                  end
               end
            end
         end
         ACCESS: begin
            if (is_write_q) begin
               state_d       = RESPOND;
               fetch_ready_d = gnt_fetch_q;
               data_ready_d  = !gnt_fetch_q;
            end else if (MEM_LATENCY <= 1) begin
               state_d = CAPTURE;
            end else begin
               state_d    = WAIT;
               wait_cnt_d = WAIT_LOAD;
            end
         end
         WAIT: begin
            if (wait_cnt_q == 3'd0) begin
               state_d = CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q - 3'd1;
            end
         end
         CAPTURE: begin
            state_d       = RESPOND;
            fetch_ready_d = gnt_fetch_q;
            data_ready_d  = !gnt_fetch_q;
            if (gnt_fetch_q) begin
               fetch_data_d = mem_data_fetched;
            end else begin
               data_fetched_d = mem_data_fetched;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q            <= IDLE;
         starve_q           <= '0;
         wait_cnt_q         <= '0;
         gnt_fetch_q        <= 1'b0;
         is_write_q         <= 1'b0;
         mem_address_q      <= '0;
         mem_write_data_q   <= '0;
         mem_format_q       <= '0;
         mem_read_enable_q  <= 1'b0;
         mem_write_enable_q <= 1'b0;
         fetch_ready_q      <= 1'b0;
         data_ready_q       <= 1'b0;
         fetch_data_q       <= '0;
         data_fetched_q     <= '0;
      end else begin
         state_q            <= state_d;
         starve_q           <= starve_d;
         wait_cnt_q         <= wait_cnt_d;
         gnt_fetch_q        <= gnt_fetch_d;
         is_write_q         <= is_write_d;
         mem_address_q      <= mem_address_d;
         mem_write_data_q   <= mem_write_data_d;
         mem_format_q       <= mem_format_d;
         mem_read_enable_q  <= mem_read_enable_d;
         mem_write_enable_q <= mem_write_enable_d;
         fetch_ready_q      <= fetch_ready_d;
         data_ready_q       <= data_ready_d;
         fetch_data_q       <= fetch_data_d;
         data_fetched_q     <= data_fetched_d;
      end
   end

   assign mem_address      = mem_address_q;
   assign mem_write_data   = mem_write_data_q;
   assign mem_format       = mem_format_q;
   assign mem_read_enable  = mem_read_enable_q;
   assign mem_write_enable = mem_write_enable_q;
   assign fetch_ready      = fetch_ready_q;
   assign data_ready       = data_ready_q;
   assign fetch_data       = fetch_data_q;
   assign data_fetched     = data_fetched_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: two instances (MEM_LATENCY 1 and 3) share stimulus and are
// compared every cycle against a transaction-level timing model, plus literal scenario checks.

module tb_memory_bus_arbiter;

   localparam int SL = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_address;
   logic        data_req;
   logic        data_write;
   logic [31:0] data_address;
   logic [31:0] data_write_data;
   logic [2:0]  data_format;

   logic        fready [2];
   logic [31:0] fdata  [2];
   logic        dready [2];
   logic [31:0] ddata  [2];
   logic [31:0] maddr  [2];
   logic [31:0] mwd    [2];
   logic [2:0]  mfmt   [2];
   logic        ren    [2];
   logic        wen    [2];
   logic [31:0] mrd    [2];

   always #5 clock = ~clock;

   memory_bus_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(SL)) u_ml1 (
      .clock(clock), .reset(reset),
      .fetch_req(fetch_req), .fetch_address(fetch_address),
      .fetch_ready(fready[0]), .fetch_data(fdata[0]),
      .data_req(data_req), .data_write(data_write), .data_address(data_address),
      .data_write_data(data_write_data), .data_format(data_format),
      .data_ready(dready[0]), .data_fetched(ddata[0]),
      .mem_address(maddr[0]), .mem_write_data(mwd[0]), .mem_format(mfmt[0]),
      .mem_read_enable(ren[0]), .mem_write_enable(wen[0]), .mem_data_fetched(mrd[0])
   );

   memory_bus_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(SL)) u_ml3 (
      .clock(clock), .reset(reset),
      .fetch_req(fetch_req), .fetch_address(fetch_address),
      .fetch_ready(fready[1]), .fetch_data(fdata[1]),
      .data_req(data_req), .data_write(data_write), .data_address(data_address),
      .data_write_data(data_write_data), .data_format(data_format),
      .data_ready(dready[1]), .data_fetched(ddata[1]),
      .mem_address(maddr[1]), .mem_write_data(mwd[1]), .mem_format(mfmt[1]),
      .mem_read_enable(ren[1]), .mem_write_enable(wen[1]), .mem_data_fetched(mrd[1])
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // transaction model state
   bit          m_busy [2];
   int          m_k    [2];
   int          m_resp [2];
   bit          m_f    [2];
   bit          m_w    [2];
   int          m_starve [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd   [2];
   logic [2:0]  m_fmt  [2];
   logic [31:0] m_fdata [2];
   logic [31:0] m_ddata [2];
   bit          e_ren [2], e_wen [2], e_fr [2], e_dr [2];

   // memory device pipelines and observation records
   logic        pv [2][9];
   logic [31:0] pd [2][9];
   int          ren_cnt [2], wen_cnt [2], fr_cnt [2], dr_cnt [2];
   logic [31:0] last_ren_addr [2];
   bit          log_en;
   int          log_n [2];
   logic [9:0]  glog  [2];

   function automatic int mlat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h0051_3023;
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         e_ren[i] = 0; e_wen[i] = 0; e_fr[i] = 0; e_dr[i] = 0;
         if (!reset) begin
            m_busy[i] = 0; m_starve[i] = 0; m_f[i] = 0; m_w[i] = 0;
            m_addr[i] = '0; m_wd[i] = '0; m_fmt[i] = '0; m_fdata[i] = '0; m_ddata[i] = '0;
         end else begin
            if (!m_busy[i]) begin
               if (fetch_req || data_req) begin
                  m_f[i] = fetch_req && (!data_req || m_starve[i] == SL);
                  if (m_f[i]) begin
                     m_starve[i] = 0;
                     m_w[i] = 0; m_addr[i] = fetch_address; m_fmt[i] = 3'b010;
                  end else begin
                     if (!fetch_req) m_starve[i] = 0;
                     else if (m_starve[i] < SL) m_starve[i] = m_starve[i] + 1;
                     m_w[i] = data_write; m_addr[i] = data_address;
                     m_wd[i] = data_write_data; m_fmt[i] = data_format;
                  end
                  m_busy[i] = 1;
                  m_k[i]    = 1;
                  m_resp[i] = m_w[i] ? 2 : mlat(i) + 2;
               end
            end else begin
               m_k[i]++;
               if (m_k[i] > m_resp[i]) m_busy[i] = 0;
            end
            if (m_busy[i]) begin
               if (m_k[i] == 1) begin
                  e_ren[i] = !m_w[i];
                  e_wen[i] = m_w[i];
               end
               if (m_k[i] == m_resp[i]) begin
                  e_fr[i] = m_f[i];
                  e_dr[i] = !m_f[i];
                  if (!m_w[i]) begin
                     if (m_f[i]) m_fdata[i] = memf(m_addr[i]);
                     else        m_ddata[i] = memf(m_addr[i]);
                  end
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d fetch_ready", i),  32'(fready[i]), 32'(e_fr[i]));
         chk($sformatf("u%0d data_ready", i),   32'(dready[i]), 32'(e_dr[i]));
         chk($sformatf("u%0d read_enable", i),  32'(ren[i]),    32'(e_ren[i]));
         chk($sformatf("u%0d write_enable", i), 32'(wen[i]),    32'(e_wen[i]));
         chk($sformatf("u%0d mem_address", i),  maddr[i],       m_addr[i]);
         chk($sformatf("u%0d mem_format", i),   32'(mfmt[i]),   32'(m_fmt[i]));
         if (!m_f[i]) chk($sformatf("u%0d mem_write_data", i), mwd[i], m_wd[i]);
         chk($sformatf("u%0d fetch_data", i),   fdata[i],       m_fdata[i]);
         chk($sformatf("u%0d data_fetched", i), ddata[i],       m_ddata[i]);
         if (ren[i] === 1'b1) begin ren_cnt[i]++; last_ren_addr[i] = maddr[i]; end
         if (wen[i] === 1'b1) wen_cnt[i]++;
         if (fready[i] === 1'b1) fr_cnt[i]++;
         if (dready[i] === 1'b1) dr_cnt[i]++;
         if (log_en && log_n[i] < 10 && (fready[i] === 1'b1 || dready[i] === 1'b1)) begin
            glog[i][log_n[i]] = fready[i];
            log_n[i]++;
         end
      end
   endtask

   // Read data is valid on the bus for exactly the one edge MEM_LATENCY cycles after the enable.
   task automatic mem_shift();
      for (int i = 0; i < 2; i++) begin
         for (int s = 8; s > 0; s--) begin
            pv[i][s] = pv[i][s-1];
            pd[i][s] = pd[i][s-1];
         end
         pv[i][0] = ren[i];
         pd[i][0] = memf(maddr[i]);
         mrd[i] = (pv[i][mlat(i)] === 1'b1) ? pd[i][mlat(i)] : (32'hBAD0_0000 ^ 32'(cyc));
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clock);
      cyc++;
      check_outputs();
      mem_shift();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         ren_cnt[i] = 0; wen_cnt[i] = 0; fr_cnt[i] = 0; dr_cnt[i] = 0;
      end
   endtask

   task automatic wait_ready(input int i, input bit f, input int t0, input int exp_lat, input string nm);
      bit seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         tick();
         if ((f ? fready[i] : dready[i]) === 1'b1) seen = 1;
      end
      if (!seen) chk({nm, " timeout"}, 32'd0, 32'd1);
      else       chk(nm, 32'(cyc - t0 + 1), 32'(exp_lat));
   endtask

   task automatic idle_reqs();
      fetch_req = 0; data_req = 0; data_write = 0;
   endtask

   initial begin
      int t0;
      int guard;
      for (int i = 0; i < 2; i++) begin
         for (int s = 0; s < 9; s++) begin pv[i][s] = 0; pd[i][s] = '0; end
         mrd[i] = '0; log_n[i] = 0; glog[i] = '0; last_ren_addr[i] = '0;
      end
      log_en = 0;
      clear_counts();
      reset = 0;
      fetch_req = 1; fetch_address = 32'h0000_0080;
      data_req = 1; data_write = 1; data_address = 32'h0000_0010;
      data_write_data = 32'h1234_5678; data_format = 3'b001;

      // reset held with requests active
      repeat (3) tick();
      chk("reset mem_format", 32'(mfmt[0]), 32'd0);
      chk("reset write_enable", 32'(wen[1]), 32'd0);
      idle_reqs();
      reset = 1;
      repeat (2) tick();

      // fetch-only read
      clear_counts();
      fetch_req = 1; fetch_address = 32'h0000_0040; t0 = cyc;
      wait_ready(0, 1, t0, 4, "fetch lat ml1");
      chk("fetch_data ml1", fdata[0], 32'h0051_3023);
      fetch_req = 0;
      wait_ready(1, 1, t0, 6, "fetch lat ml3");
      chk("fetch_data ml3", fdata[1], 32'h0051_3023);
      chk("fetch read_enable count", 32'(ren_cnt[0]), 32'd1);
      chk("fetch mem_address", last_ren_addr[0], 32'h0000_0040);
      repeat (4) tick();

      // store
      clear_counts();
      data_req = 1; data_write = 1; data_address = 32'h1001_0000;
      data_write_data = 32'hDEAD_BEEF; data_format = 3'b010; t0 = cyc;
      wait_ready(0, 0, t0, 3, "store lat ml1");
      chk("store ready ml3 same cycle", 32'(dready[1]), 32'd1);
      idle_reqs();
      chk("store data_fetched unchanged", ddata[0], 32'd0);
      chk("store write_enable count", 32'(wen[0]), 32'd0);
      repeat (4) tick();
      chk("store write_enable total", 32'(wen_cnt[0]), 32'd1);

      // MEM_LATENCY=3 load
      data_req = 1; data_write = 0; data_address = 32'h2000_0004;
      data_format = 3'b010; t0 = cyc;
      wait_ready(0, 0, t0, 4, "load lat ml1");
      wait_ready(1, 0, t0, 6, "load lat ml3");
      chk("load data ml3", ddata[1], 32'h7A5A_5A5E);
      idle_reqs();
      repeat (12) tick();

      // contention: both held high
      fetch_req = 1; fetch_address = 32'h0000_0100;
      data_req = 1; data_write = 0; data_address = 32'h0000_0300; data_format = 3'b001;
      log_en = 1;
      guard = 0;
      while ((log_n[0] < 10 || log_n[1] < 10) && guard < 300) begin
         tick();
         guard++;
      end
      log_en = 0;
      idle_reqs();
      chk("grant order ml1", 32'(glog[0]), 32'b10_0001_0000);
      chk("grant order ml3", 32'(glog[1]), 32'b10_0001_0000);
      repeat (15) tick();

      // reset during a read in flight
      clear_counts();
      data_req = 1; data_write = 0; data_address = 32'h2000_0008; data_format = 3'b010;
      tick();
      tick();
      reset = 0; data_req = 0;
      tick();
      reset = 1;
      chk("abort mem_address", maddr[1], 32'd0);
      chk("abort data_fetched", ddata[1], 32'd0);
      repeat (10) tick();
      chk("abort no ready ml1", 32'(dr_cnt[0]), 32'd0);
      chk("abort no ready ml3", 32'(dr_cnt[1]), 32'd0);

      // request dropped one cycle after grant
      clear_counts();
      data_req = 1; data_write = 0; data_address = 32'h0000_0044; data_format = 3'b100; t0 = cyc;
      tick();
      data_req = 0;
      wait_ready(0, 0, t0, 4, "dropped req lat ml1");
      chk("dropped req data ml1", ddata[0], 32'h5A5A_5A1E);
      wait_ready(1, 0, t0, 6, "dropped req lat ml3");
      repeat (10) tick();
      chk("dropped req pulses ml1", 32'(dr_cnt[0]), 32'd1);
      chk("dropped req pulses ml3", 32'(dr_cnt[1]), 32'd1);
      chk("dropped req enables ml1", 32'(ren_cnt[0]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
